// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline types and default widths for pipeline stages.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int PIPE_DATA_W = 16;
    localparam int PIPE_CTRL_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Number of held entries for a given state; the encoding never yields 3.
    function automatic logic [1:0] occupancy_of(input skid_state_t s);
        case (s)
            ONE:     occupancy_of = 2'd1;
            FULL:    occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Two-entry skid buffer pipeline stage, fully registered
//                handshake outputs (in_ready never sees out_ready directly).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = PIPE_DATA_W,
    parameter int CTRL_W     = PIPE_CTRL_W,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    skid_state_t       r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [1:0]        r_occupancy;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_push;
    logic w_pop;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    // Handshake flags and occupancy are kept as their own flops so every
    // output is a register, updated alongside the state they mirror.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= occupancy_of(EMPTY);
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= occupancy_of(EMPTY);
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                        r_occupancy <= occupancy_of(ONE);
                    end
                end
                ONE: begin
                    case ({w_push, w_pop})
                        2'b11: begin
                            r_main_ctrl <= in_ctrl;
                            r_main_data <= in_data;
                        end
                        2'b10: begin
                            r_skid_ctrl <= in_ctrl;
                            r_skid_data <= in_data;
                            r_state     <= FULL;
                            r_in_ready  <= 1'b0;
                            r_occupancy <= occupancy_of(FULL);
                        end
                        2'b01: begin
                            // A bubble must never carry a stale regWrite.
                            r_main_ctrl <= '0;
                            if (CLEAR_DATA != 0) begin
                                r_main_data <= '0;
                            end
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                            r_occupancy <= occupancy_of(EMPTY);
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (w_pop) begin
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                        r_state     <= ONE;
                        r_in_ready  <= 1'b1;
                        r_occupancy <= occupancy_of(ONE);
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_occupancy <= occupancy_of(EMPTY);
                    r_main_ctrl <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign occupancy = r_occupancy;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
//  Module      : tb_pipe_skid_stage
//  Description : Directed and random self-checking bench for pipe_skid_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_ctrl;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready,  in_ready_c;
    logic        out_valid, out_valid_c;
    logic [7:0]  out_ctrl,  out_ctrl_c;
    logic [15:0] out_data,  out_data_c;
    logic [1:0]  occupancy, occupancy_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(16), .CTRL_W(8), .CLEAR_DATA(0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_skid_stage #(.DATA_W(16), .CTRL_W(8), .CLEAR_DATA(1)) dut_clr (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_ctrl(out_ctrl_c), .out_data(out_data_c),
        .occupancy(occupancy_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [15:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_out_ctrl"},  {24'd0, out_ctrl},  32'd0);
        check_eq({tag, "_occ"},       {30'd0, occupancy}, 32'd0);
        check_eq({tag, "_clr_ctrl"},  {24'd0, out_ctrl_c}, 32'd0);
        check_eq({tag, "_clr_occ"},   {30'd0, occupancy_c}, 32'd0);
    endtask

    logic [23:0] sb_q[$];
    logic [23:0] exp_e;
    int          seq;
    logic        m_push, m_pop, ir_before;

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h00, 16'h0000);
        #3;
        check_empty("reset");
        check_eq("reset_out_data",   {16'd0, out_data},   32'd0);
        check_eq("reset_clr_data",   {16'd0, out_data_c}, 32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, i[7:0], i[15:0]);
            step();
            check_eq("stream_data",     {16'd0, out_data},   i);
            check_eq("stream_valid",    {31'd0, out_valid},  32'd1);
            check_eq("stream_occ",      {30'd0, occupancy},  32'd1);
            check_eq("stream_in_ready", {31'd0, in_ready},   32'd1);
        end
        drive(1'b0, 8'h00, 16'h0000);
        step();
        check_empty("stream_end");
        check_eq("stream_hold_data", {16'd0, out_data},   32'h5);
        check_eq("stream_clr_data",  {16'd0, out_data_c}, 32'h0);

        // Stall fill, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 8'h0A, 16'hAAAA);
        step();
        check_eq("fill1_occ",  {30'd0, occupancy}, 32'd1);
        check_eq("fill1_data", {16'd0, out_data},  32'hAAAA);
        drive(1'b1, 8'h0B, 16'hBBBB);
        step();
        check_eq("fill2_occ",      {30'd0, occupancy}, 32'd2);
        check_eq("fill2_in_ready", {31'd0, in_ready},  32'd0);
        check_eq("fill2_data",     {16'd0, out_data},  32'hAAAA);
        drive(1'b1, 8'h0C, 16'hCCCC);
        step();
        check_eq("fill3_occ",  {30'd0, occupancy}, 32'd2);
        check_eq("fill3_data", {16'd0, out_data},  32'hAAAA);
        check_eq("fill3_ctrl", {24'd0, out_ctrl},  32'h0A);
        out_ready = 1'b1;
        step();
        check_eq("drain1_data",     {16'd0, out_data}, 32'hBBBB);
        check_eq("drain1_occ",      {30'd0, occupancy}, 32'd1);
        check_eq("drain1_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("drain2_data", {16'd0, out_data}, 32'hCCCC);
        check_eq("drain2_ctrl", {24'd0, out_ctrl}, 32'h0C);
        drive(1'b0, 8'h00, 16'h0000);
        step();
        check_empty("drain_end");

        // Flush while FULL with a pending input
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 16'h0011); step();
        drive(1'b1, 8'h22, 16'h0022); step();
        check_eq("pre_flush_occ", {30'd0, occupancy}, 32'd2);
        drive(1'b1, 8'h34, 16'h1234);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_empty("flush_full");
        check_eq("flush_clr_data", {16'd0, out_data_c}, 32'h0);
        drive(1'b0, 8'h00, 16'h0000);
        out_ready = 1'b1;
        step();
        check_eq("flush_no_1234", {31'd0, out_valid}, 32'd0);

        // Flush in ONE drops a same-cycle push
        drive(1'b1, 8'h55, 16'h0055); step();
        drive(1'b1, 8'h34, 16'h1234);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 16'h0000);
        check_empty("flush_one");
        step();
        check_eq("flush_one_after", {31'd0, out_valid}, 32'd0);

        // Bubble clears ctrl; data cleared only with CLEAR_DATA
        drive(1'b1, 8'hFF, 16'hBEEF);
        step();
        check_eq("bubble_ctrl_in", {24'd0, out_ctrl}, 32'hFF);
        drive(1'b0, 8'h00, 16'h0000);
        step();
        check_eq("bubble_ctrl",     {24'd0, out_ctrl},   32'h00);
        check_eq("bubble_clr_ctrl", {24'd0, out_ctrl_c}, 32'h00);
        check_eq("bubble_data",     {16'd0, out_data},   32'hBEEF);
        check_eq("bubble_clr_data", {16'd0, out_data_c}, 32'h0000);

        // Asynchronous reset mid-cycle while FULL
        out_ready = 1'b0;
        drive(1'b1, 8'h71, 16'h0071); step();
        drive(1'b1, 8'h72, 16'h0072); step();
        drive(1'b0, 8'h00, 16'h0000);
        check_eq("pre_reset_occ", {30'd0, occupancy}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_empty("async_reset");
        check_eq("async_reset_data", {16'd0, out_data}, 32'h0);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'hC3, 16'h00C3);
        step();
        check_eq("post_reset_data",  {16'd0, out_data},  32'h00C3);
        check_eq("post_reset_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 8'h00, 16'h0000);
        step();
        check_empty("post_reset_end");

        // Random traffic against a queue scoreboard
        sb_q.delete();
        seq = 1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = 1'($urandom % 2);
            out_ready = 1'($urandom % 2);
            in_data   = seq[15:0];
            in_ctrl   = seq[7:0] ^ 8'h5A;
            #2;
            ir_before = in_ready;
            out_ready = ~out_ready;
            #1;
            check_eq("rnd_in_ready_comb", {31'd0, in_ready}, {31'd0, ir_before});
            out_ready = ~out_ready;
            #1;
            m_push = in_valid && (sb_q.size() < 2);
            m_pop  = (sb_q.size() > 0) && out_ready;
            check_eq("rnd_in_ready",  {31'd0, in_ready},  {31'd0, sb_q.size() < 2});
            check_eq("rnd_out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() > 0});
            check_eq("rnd_occ",       {30'd0, occupancy}, sb_q.size());
            if (sb_q.size() > 0) begin
                exp_e = sb_q[0];
                check_eq("rnd_data", {16'd0, out_data}, {16'd0, exp_e[15:0]});
                check_eq("rnd_ctrl", {24'd0, out_ctrl}, {24'd0, exp_e[23:16]});
            end else begin
                check_eq("rnd_bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
            end
            @(posedge clk);
            #1;
            if (m_pop)  void'(sb_q.pop_front());
            if (m_push) begin
                sb_q.push_back({in_ctrl, in_data});
                seq++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the payload width (ALU result, read data, PC+2, store data).
REQ-002 The block SHALL have parameter CTRL_W, default 8, giving the control-bit width (regWrite, resultSrc, rd).
REQ-003 The block SHALL have parameter CLEAR_DATA, default 0; when 1, payload is zeroed on flush and on empty, as well as control.
REQ-004 The block SHALL have port clk, input, 1 bit: clock. Reset is reset, asynchronous, active-high; the clock is clk.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-007 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_ctrl (input, CTRL_W) and in_data (input, DATA_W): the upstream handshake.
REQ-008 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_ctrl (output, CTRL_W) and out_data (output, DATA_W): the downstream handshake.
REQ-009 The block SHALL have port occupancy, output, 2 bits: number of held entries (0..2).

Function
REQ-010 The block SHALL be a two-entry skid buffer with states EMPTY, ONE and FULL, holding a main entry (drives the outputs) and a skid entry.
REQ-011 The block SHALL define push as in_valid && in_ready, and pop as out_valid && out_ready.
REQ-012 in_ready SHALL equal (state != FULL) and SHALL be driven from a register only, with no combinational path from out_ready.
REQ-013 out_valid SHALL equal (state != EMPTY).
REQ-014 Latency SHALL be 1 cycle: data pushed at edge N is presented on out_* after edge N when the block was EMPTY.
REQ-015 In EMPTY, push SHALL load main and go to ONE.
REQ-016 In ONE, push without pop SHALL load skid and go to FULL.
REQ-017 In ONE, pop without push SHALL go to EMPTY.
REQ-018 In ONE, simultaneous push and pop SHALL load main with new data and stay in ONE.
REQ-019 In FULL, pop SHALL move skid into main and go to ONE; no push is possible in FULL.
REQ-020 Ordering SHALL be strict FIFO, with no loss or duplication of entries under any in_valid/out_ready pattern.
REQ-021 Whenever out_valid=0, out_ctrl SHALL be 0 (a bubble carries no regWrite); out_data SHALL be 0 only if CLEAR_DATA=1, otherwise it holds its last value.
REQ-022 flush SHALL have highest priority: at the edge it goes to EMPTY, a push presented in the same cycle is dropped, and a pop in the same cycle completes downstream but the state is still EMPTY.
REQ-023 After a flush edge, in_ready=1, out_valid=0, out_ctrl=0 and occupancy=0.
REQ-024 occupancy SHALL be 0, 1 or 2 for EMPTY, ONE or FULL respectively; the value 3 SHALL never occur.
REQ-025 Held entries SHALL NOT change while out_valid && !out_ready (stall hold).

Reset
REQ-026 On reset, state SHALL be EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_data=0 and occupancy=0, immediately and independent of clk.
REQ-027 Reset asserted mid-transfer SHALL discard both entries; after release, the first push is the first output.

Structure
REQ-028 The state enum skid_state_t (EMPTY, ONE, FULL) SHALL reside in the shared package pipe_pkg.
REQ-029 DATA_W/CTRL_W defaults SHALL be taken from pipe_pkg constants.
REQ-030 The block SHALL use no sub-module; main and skid storage are inline registers.

Verification
REQ-031 The bench SHALL cover streaming: out_ready=1, push 0x0001..0x0005 in consecutive cycles -> out_data 0x0001..0x0005 one cycle later each, occupancy stays at 1, in_ready stays at 1.
REQ-032 The bench SHALL cover stall fill: out_ready=0, push 0xAAAA then 0xBBBB -> occupancy=2 and in_ready=0; a third value 0xCCCC held on the input is not accepted; raise out_ready -> outputs 0xAAAA, 0xBBBB, then 0xCCCC, in order.
REQ-033 The bench SHALL cover flush while FULL with in_valid=1 carrying 0x1234: the next cycle shows out_valid=0, out_ctrl=0, occupancy=0, and 0x1234 never appears.
REQ-034 The bench SHALL cover the bubble check: CTRL in=0xFF, then in_valid=0 -> after the pop, out_ctrl=0x00; with CLEAR_DATA=1, out_data=0x0000 as well.
REQ-035 The bench SHALL cover asynchronous reset asserted mid-cycle while FULL: outputs clear before the next clk edge; after release, push 0x00C3 -> out_data=0x00C3 one cycle later.
REQ-036 The bench SHALL run random in_valid/out_ready at 50% for 10k cycles against a scoreboard, checking no loss, no duplication, in-order delivery, and in_ready never depending combinationally on out_ready.
